// File: rtl/morse_pkg.sv
// morse_pkg: shared types and constants for the Morse letter sequencer.
// Holds the FSM state encoding, letter indices, the symbol-count limit and
// the letter ROM content (A-H) as a pure function.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_MARK  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_LGAP  = 3'd5
    } state_t;

    localparam logic [2:0] LTR_A = 3'd0;
    localparam logic [2:0] LTR_B = 3'd1;
    localparam logic [2:0] LTR_C = 3'd2;
    localparam logic [2:0] LTR_D = 3'd3;
    localparam logic [2:0] LTR_E = 3'd4;
    localparam logic [2:0] LTR_F = 3'd5;
    localparam logic [2:0] LTR_G = 3'd6;
    localparam logic [2:0] LTR_H = 3'd7;

    localparam int MAX_SYMBOLS = 4;
    localparam int IDX_W       = $clog2(MAX_SYMBOLS);

    // Returns {len[2:0], pattern[3:0]}. pattern[i] is symbol i (symbol 0 is
    // sent first); 1 = dash, 0 = dot. Bits at or above len are don't-care
    // and kept at zero.
    function automatic logic [6:0] letter_rom(input logic [2:0] ltr);
        logic [6:0] entry;
        case (ltr)
            LTR_A:   entry = {3'd2, 4'b0010};   // .-
            LTR_B:   entry = {3'd4, 4'b0001};   // -...
            LTR_C:   entry = {3'd4, 4'b0101};   // -.-.
            LTR_D:   entry = {3'd3, 4'b0001};   // -..
            LTR_E:   entry = {3'd1, 4'b0000};   // .
            LTR_F:   entry = {3'd4, 4'b0100};   // ..-.
            LTR_G:   entry = {3'd3, 4'b0011};   // --.
            LTR_H:   entry = {3'd4, 4'b0000};   // ....
            default: entry = {3'd1, 4'b0000};
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/morse_rom.sv
// morse_rom: combinational letter -> (symbol count, dash/dot pattern) lookup.
module morse_rom
    import morse_pkg::*;
(
    input  logic [2:0] letter,
    output logic [2:0] len,
    output logic [3:0] pattern
);

    // Decode the latched letter through the shared ROM function.
    always_comb begin
        {len, pattern} = letter_rom(letter);
    end

endmodule

// File: rtl/morse_sequencer.sv
// morse_sequencer: plays one Morse letter (A-H) on a registered LED output,
// timed by an external one-cycle tick enable. Handshake: start / busy / done.
// Optional build macro MORSE_REPEAT_EN adds input repeat_en and the LGAP
// state so the latched letter can be replayed with a letter gap in between.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int DOT_TICKS        = 1,
    parameter int DASH_TICKS       = 3,
    parameter int GAP_TICKS        = 1,
`ifdef MORSE_REPEAT_EN
    parameter int LETTER_GAP_TICKS = 3,
`endif
    parameter int CNT_W            = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [2:0] letter,
`ifdef MORSE_REPEAT_EN
    input  logic       repeat_en,
`endif
    output logic       led,
    output logic       busy,
    output logic       done
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [2:0]         letter_r;
    logic [2:0]         letter_nxt_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               led_r;
    logic               busy_r;
    logic               done_r;
    logic               led_nxt_s;
    logic               busy_nxt_s;
    logic               done_nxt_s;
    logic [2:0]         len_s;
    logic [3:0]         pattern_s;
    logic               last_sym_s;
    logic               cnt_one_s;

    // Duration of a mark: dash or dot length taken from the parameters.
    function automatic logic [CNT_W-1:0] mark_ticks(input logic is_dash);
        return is_dash ? CNT_W'(DASH_TICKS) : CNT_W'(DOT_TICKS);
    endfunction

    morse_rom u_rom (
        .letter  (letter_r),
        .len     (len_s),
        .pattern (pattern_s)
    );

    assign last_sym_s = ({1'b0, idx_r} == (len_s - 3'd1));
    assign cnt_one_s  = (cnt_r == CNT_W'(1));

    // Next-state, counter/index updates and output decode of the sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        letter_nxt_s = letter_r;
        idx_nxt_s    = idx_r;
        cnt_nxt_s    = cnt_r;
        led_nxt_s    = 1'b0;
        busy_nxt_s   = 1'b0;
        done_nxt_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // A tick in the same cycle as start is deliberately ignored.
                if (start) begin
                    letter_nxt_s = letter;
                    idx_nxt_s    = {IDX_W{1'b0}};
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    state_nxt_s  = ST_ALIGN;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                // Wait for a tick so the first mark spans whole tick periods.
                if (tick) begin
                    cnt_nxt_s   = mark_ticks(pattern_s[2'd0]);
                    state_nxt_s = ST_MARK;
                end else begin
                    state_nxt_s = ST_ALIGN;
                end
            end
            ST_MARK: begin
                if (tick && cnt_one_s) begin
                    if (last_sym_s) begin
`ifdef MORSE_REPEAT_EN
                        if (repeat_en) begin
                            cnt_nxt_s   = CNT_W'(LETTER_GAP_TICKS);
                            idx_nxt_s   = {IDX_W{1'b0}};
                            state_nxt_s = ST_LGAP;
                        end else begin
                            state_nxt_s = ST_DONE;
                        end
`else
                        state_nxt_s = ST_DONE;
`endif
                    end else begin
                        cnt_nxt_s   = CNT_W'(GAP_TICKS);
                        idx_nxt_s   = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        state_nxt_s = ST_GAP;
                    end
                end else if (tick) begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_GAP: begin
                // Index was already advanced on entry; load that symbol.
                if (tick && cnt_one_s) begin
                    cnt_nxt_s   = mark_ticks(pattern_s[idx_r]);
                    state_nxt_s = ST_MARK;
                end else if (tick) begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
`ifdef MORSE_REPEAT_EN
            ST_LGAP: begin
                if (tick && cnt_one_s) begin
                    cnt_nxt_s   = mark_ticks(pattern_s[2'd0]);
                    idx_nxt_s   = {IDX_W{1'b0}};
                    state_nxt_s = ST_MARK;
                end else if (tick) begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
`endif
            ST_DONE: begin
                // Single-cycle completion state; start is not sampled here.
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and then registered, so
        // they line up with the state they describe.
        case (state_nxt_s)
            ST_ALIGN: busy_nxt_s = 1'b1;
            ST_MARK: begin
                busy_nxt_s = 1'b1;
                led_nxt_s  = 1'b1;
            end
            ST_GAP:   busy_nxt_s = 1'b1;
            ST_LGAP:  busy_nxt_s = 1'b1;
            ST_DONE:  done_nxt_s = 1'b1;
            default: begin
                led_nxt_s  = 1'b0;
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // State, latched letter, counters and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            letter_r <= 3'd0;
            idx_r    <= {IDX_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            led_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            letter_r <= letter_nxt_s;
            idx_r    <= idx_nxt_s;
            cnt_r    <= cnt_nxt_s;
            led_r    <= led_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    assign led  = led_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_morse_sequencer.sv
// tb_morse_sequencer: table-driven and randomized check of morse_sequencer.
// Tick is high on every 4th clock edge. Expected LED/busy/done per edge is
// derived from the Morse code strings and the tick timing alone.
module tb_morse_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [2:0] letter = 3'd0;
`ifdef MORSE_REPEAT_EN
    logic       repeat_en = 1'b0;
`endif
    logic       led, busy, done;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    localparam int DOT = 1, DASH = 3, GAP = 1;

    morse_sequencer dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .tick     (tick),
        .start    (start),
        .letter   (letter),
`ifdef MORSE_REPEAT_EN
        .repeat_en(repeat_en),
`endif
        .led      (led),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ltr;
        int         phase;
        string      lv;     // expected LED level per tick period
    } vec_t;

    vec_t tbl [8];

    // Advance one clock edge; tick is high on every edge divisible by 4.
    task automatic step();
        tick = (((edge_n + 1) % 4) == 0);
        @(posedge clk);
        edge_n = edge_n + 1;
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s edge=%0d {led,busy,done} got=%b want=%b", name, edge_n, act, exp);
        end
    endtask

    // Reference: LED level per tick period built from the dot/dash string.
    function automatic string levels_of(input logic [2:0] l);
        string code;
        string s;
        int n;
        s = "";
        case (l)
            3'd0: code = ".-";
            3'd1: code = "-...";
            3'd2: code = "-.-.";
            3'd3: code = "-..";
            3'd4: code = ".";
            3'd5: code = "..-.";
            3'd6: code = "--.";
            default: code = "....";
        endcase
        for (int i = 0; i < code.len(); i++) begin
            if (i > 0) for (int g = 0; g < GAP; g++) s = {s, "0"};
            n = (code.getc(i) == "-") ? DASH : DOT;
            for (int k = 0; k < n; k++) s = {s, "1"};
        end
        return s;
    endfunction

    // Start a letter when the accepting edge has the given tick phase, then
    // check every edge until two cycles after done. With noise, stray start
    // pulses and letter changes are injected while the letter is running.
    task automatic run_letter(input string name, input logic [2:0] ltr,
                              input string lv, input int phase, input bit noise);
        int a, k, t, e_done, p;
        logic [2:0] exp;
        for (int w = 0; w < 4 && ((edge_n + 1) % 4) != phase; w++) step();
        a = edge_n + 1;
        letter = ltr;
        start = 1'b1;
        step();
        start = 1'b0;
        k = a + 4 - (a % 4);
        t = lv.len();
        e_done = k + 4 * t;
        for (int e = a; e <= e_done + 2; e++) begin
            if (e > a) begin
                if (noise) begin
                    letter = 3'($urandom_range(0, 7));
                    start  = (e <= e_done) && ($urandom_range(0, 2) == 0);
                end
                step();
                start = 1'b0;
            end
            p = (e - k) / 4;
            exp[2] = (e >= k && e < e_done) ? (lv.getc(p) == "1") : 1'b0;
            exp[1] = (e >= a && e < e_done);
            exp[0] = (e == e_done);
            chk(name, {led, busy, done}, exp);
        end
    endtask

    initial begin
        int a, k;
        tbl[0] = '{3'd0, 1, "10111"};
        tbl[1] = '{3'd1, 2, "111010101"};
        tbl[2] = '{3'd2, 3, "11101011101"};
        tbl[3] = '{3'd3, 0, "1110101"};
        tbl[4] = '{3'd4, 1, "1"};
        tbl[5] = '{3'd5, 2, "101011101"};
        tbl[6] = '{3'd6, 3, "111011101"};
        tbl[7] = '{3'd7, 0, "1010101"};

        // Reset state.
        reset = 1'b1;
        step();
        step();
        chk("reset", {led, busy, done}, 3'b000);
        reset = 1'b0;
        step();
        chk("idle", {led, busy, done}, 3'b000);

        // Table: every letter against hand-written expected LED levels.
        for (int i = 0; i < 8; i++) begin
            run_letter("table", tbl[i].ltr, tbl[i].lv, tbl[i].phase, 1'b0);
        end

        // Start coinciding with a tick, stray starts/letter changes mid-run.
        run_letter("a_tick_aligned", 3'd0, "10111", 0, 1'b1);

        // Reset during G's first dash: aborts silently, then E runs normally.
        for (int w = 0; w < 4 && ((edge_n + 1) % 4) != 1; w++) step();
        a = edge_n + 1;
        letter = 3'd6;
        start = 1'b1;
        step();
        start = 1'b0;
        k = a + 4 - (a % 4);
        while (edge_n < k + 5) begin
            step();
        end
        chk("g_in_dash", {led, busy, done}, 3'b110);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("g_reset", {led, busy, done}, 3'b000);
        for (int w = 0; w < 40; w++) begin
            step();
            chk("g_abort_quiet", {led, busy, done}, 3'b000);
        end
        run_letter("e_after_reset", 3'd4, "1", 2, 1'b0);

        // Randomized letters, phases and noise against the reference model.
        for (int r = 0; r < 24; r++) begin
            logic [2:0] l;
            l = 3'($urandom_range(0, 7));
            run_letter("random", l, levels_of(l), int'($urandom_range(0, 3)), 1'b1);
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                step();
                chk("random_idle", {led, busy, done}, 3'b000);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
